// File: rtl/memory_array.sv
// Flip-flop word array with single-cycle registered reads, ignored out-of-range
// writes and a word-per-cycle clear sequence.
module memory_array #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             rw,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] in,
  input  logic             clr,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic             acc;

  assign ready = (state == IDLE) && !clr;
  assign acc   = sel && ready;

  // Decoded read mux: addresses with no matching word yield zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) begin
        rd_data = mem[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
          end else if (sel && !rw) begin
            out       <= rd_data;
            out_valid <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write decode only matches in-range words, so out-of-range writes fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (state == CLEAR && cnt == AW'(i)) begin
          mem[i] <= '0;
        end else if (acc && rw && addr == AW'(i)) begin
          mem[i] <= in;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_array.sv
// Drives a 16-deep and a 10-deep instance with shared stimulus and checks both
// against an array-based model every cycle, plus directed literal checks.
module tb_memory_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sel = 1'b0;
  logic       rw = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] out16, out10;
  logic       v16, v10, r16, r10;

  int n_checks = 0;
  int n_fail = 0;
  logic rdy_pre;

  memory_array #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr), .in(din),
    .clr(clr), .ready(r16), .out(out16), .out_valid(v16)
  );

  memory_array #(.WIDTH(8), .DEPTH(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr), .in(din),
    .clr(clr), .ready(r10), .out(out10), .out_valid(v10)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = 16-deep, index 1 = 10-deep.
  logic [7:0] mm [2][16];
  int         cl [2];
  logic [7:0] mo [2];
  bit         mv [2];
  bit         lastrd [2];

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 10;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mm[k][i] = 8'h00;
      cl[k] = 0;
      mo[k] = 8'h00;
      mv[k] = 1'b0;
      lastrd[k] = 1'b0;
    end
  endtask

  // Inputs are stable from posedge+1 onward, so at negedge the model can be
  // compared and then advanced over the coming rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("out16", 32'(out16), 32'(mo[0]));
      chk("valid16", 32'(v16), 32'(mv[0]));
      chk("ready16", 32'(r16), 32'(cl[0] == 0 && !clr));
      chk("out10", 32'(out10), 32'(mo[1]));
      chk("valid10", 32'(v10), 32'(mv[1]));
      chk("ready10", 32'(r10), 32'(cl[1] == 0 && !clr));
      if (v16) chk("valid16_needs_read", 32'(lastrd[0]), 32'd1);
      if (v10) chk("valid10_needs_read", 32'(lastrd[1]), 32'd1);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          lastrd[k] = 1'b0;
          if (cl[k] > 0) begin
            mm[k][dep(k) - cl[k]] = 8'h00;
            cl[k] = cl[k] - 1;
            mv[k] = 1'b0;
          end else if (clr) begin
            cl[k] = dep(k);
            mv[k] = 1'b0;
          end else if (sel && rw) begin
            if (int'(addr) < dep(k)) mm[k][addr] = din;
            mv[k] = 1'b0;
          end else if (sel) begin
            mo[k] = (int'(addr) < dep(k)) ? mm[k][addr] : 8'h00;
            mv[k] = 1'b1;
            lastrd[k] = 1'b1;
          end else begin
            mv[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive(input logic s, input logic r, input logic [3:0] a,
                       input logic [7:0] d, input logic c);
    sel = s; rw = r; addr = a; din = d; clr = c;
    #1 rdy_pre = r16;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3;
    chk("rst_out", 32'(out16), 32'h0);
    chk("rst_valid", 32'(v16), 32'h0);
    chk("rst_ready", 32'(r16), 32'h1);
    clr = 1'b1;
    #0.5;
    chk("rst_ready_clr", 32'(r16), 32'h0);
    clr = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read of one address.
    drive(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
    chk("wr_valid", 32'(v16), 32'h0);
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    chk("rd_out", 32'(out16), 32'hA5);
    chk("rd_valid", 32'(v16), 32'h1);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("hold_valid", 32'(v16), 32'h0);
    chk("hold_out", 32'(out16), 32'hA5);

    // Back-to-back fill and reverse read.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'(i), 8'(i) ^ 8'hFF, 1'b0);
      chk("b2b_wr_ready", 32'(rdy_pre), 32'h1);
    end
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
      chk("b2b_rd_ready", 32'(rdy_pre), 32'h1);
      chk("b2b_rd_out", 32'(out16), 32'(8'(i) ^ 8'hFF));
      chk("b2b_rd_valid", 32'(v16), 32'h1);
    end

    // Out-of-range write/read on the 10-deep instance.
    drive(1'b1, 1'b1, 4'd12, 8'h3C, 1'b0);
    drive(1'b1, 1'b0, 4'd12, 8'h00, 1'b0);
    chk("oor_out10", 32'(out10), 32'h00);
    chk("oor_valid10", 32'(v10), 32'h1);
    chk("oor_out16", 32'(out16), 32'h3C);
    drive(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    chk("oor_intact10", 32'(out10), 32'hFD);

    // Clear with a simultaneous request, then requests held during CLEAR.
    drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b1);
    chk("clr_ready", 32'(rdy_pre), 32'h0);
    chk("clr_not_accepted", 32'(v16), 32'h0);
    chk("clr_out_hold", 32'(out16), 32'hFD);
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 1'b1, 4'(j), 8'h77, (j < 15) ? 1'b1 : 1'b0);
      chk("clearing_ready", 32'(rdy_pre), 32'h0);
      chk("clearing_valid", 32'(v16), 32'h0);
      chk("clearing_out", 32'(out16), 32'hFD);
    end
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("post_clr_ready", 32'(rdy_pre), 32'h1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
      chk("post_clr_rd", 32'(out16), 32'h00);
      chk("post_clr_valid", 32'(v16), 32'h1);
    end

    // Reset during the fifth CLEAR cycle.
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 4'd7, 8'h5A, 1'b0);
    drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    chk("pre_rst_out", 32'(out16), 32'h5A);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("clr_cnt_cycle5", 32'(dut16.cnt), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out16), 32'h0);
    chk("mid_rst_valid", 32'(v16), 32'h0);
    chk("mid_rst_cnt", 32'(dut16.cnt), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #0.5;
    chk("rel_ready", 32'(r16), 32'h1);
    drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    chk("rel_rd7", 32'(out16), 32'h00);
    chk("rel_valid", 32'(v16), 32'h1);
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    chk("rel_rd3", 32'(out16), 32'h00);

    // Random traffic with occasional clears and asynchronous resets.
    repeat (800) begin
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            8'($urandom),
            ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
    end
    repeat (3) drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
